// File: rtl/pmem_burst_responder_if.sv
// rtl/pmem_burst_responder_if.sv - physical-memory burst port between initiator and responder
interface pmem_burst_responder_if;
    logic        pmem_read;
    logic        pmem_write;
    logic [31:0] pmem_address;
    logic [63:0] pmem_wdata;
    logic        pmem_resp;
    logic [63:0] pmem_rdata;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );
endinterface

// File: rtl/pmem_burst_responder.sv
// rtl/pmem_burst_responder.sv - four-beat line burst memory responder with programmable latency
module pmem_burst_responder #(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    pmem_burst_responder_if.slave   bus,
    output logic                    busy,
    output logic                    proto_err,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
);
    localparam int LW = $clog2(DEPTH_LINES);
    localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, WAIT, BURST, RECOVER} state_t;

    state_t           state;
    logic             dir_wr;
    logic [LW-1:0]    line;
    logic [26:0]      tag;
    logic [1:0]       beat;
    logic [CW-1:0]    count;

    // One 64-bit word per beat; a line occupies four consecutive words.
    logic [63:0]      mem [DEPTH_LINES*4];

    logic             req_rd;
    logic             req_wr;
    logic [LW-1:0]    req_line;
    logic             req_lost;
    logic             addr_moved;
    logic             viol;
    logic             mem_we;

    assign req_rd     = bus.pmem_read & ~bus.pmem_write;
    assign req_wr     = bus.pmem_write & ~bus.pmem_read;
    assign req_line   = bus.pmem_address[5 +: LW];
    assign req_lost   = dir_wr ? (~bus.pmem_write | bus.pmem_read)
                               : (~bus.pmem_read | bus.pmem_write);
    assign addr_moved = bus.pmem_address[31:5] != tag;
    assign viol       = req_lost | addr_moved;

    // Not reset: an async reset mid-write drops state first, so no further beat commits.
    assign mem_we = (state == BURST) && dir_wr;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{line, beat}] <= bus.pmem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            dir_wr         <= 1'b0;
            line           <= '0;
            tag            <= '0;
            beat           <= 2'd0;
            count          <= '0;
            busy           <= 1'b0;
            proto_err      <= 1'b0;
            rd_count       <= 32'd0;
            wr_count       <= 32'd0;
            bus.pmem_resp  <= 1'b0;
            bus.pmem_rdata <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_rd || req_wr) begin
                        dir_wr <= req_wr;
                        line   <= req_line;
                        tag    <= bus.pmem_address[31:5];
                        beat   <= 2'd0;
                        busy   <= 1'b1;
                        if (LATENCY == 0) begin
                            state         <= BURST;
                            bus.pmem_resp <= 1'b1;
                            if (req_rd) begin
                                bus.pmem_rdata <= mem[{req_line, 2'b00}];
                            end
                        end else begin
                            state <= WAIT;
                            count <= CW'(LATENCY);
                        end
                    end else if (bus.pmem_read && bus.pmem_write) begin
                        proto_err <= 1'b1;
                    end
                end
                WAIT: begin
                    if (viol) begin
                        proto_err <= 1'b1;
                    end
                    // Leaving on count==1 puts the first beat exactly LATENCY idle cycles after accept.
                    if (count == CW'(1)) begin
                        state         <= BURST;
                        bus.pmem_resp <= 1'b1;
                        if (!dir_wr) begin
                            bus.pmem_rdata <= mem[{line, 2'b00}];
                        end
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                BURST: begin
                    if (viol) begin
                        proto_err <= 1'b1;
                    end
                    if (beat == 2'd3) begin
                        state         <= RECOVER;
                        bus.pmem_resp <= 1'b0;
                        if (dir_wr) begin
                            wr_count <= wr_count + 32'd1;
                        end else begin
                            rd_count <= rd_count + 32'd1;
                        end
                    end else begin
                        beat <= beat + 2'd1;
                        if (!dir_wr) begin
                            bus.pmem_rdata <= mem[{line, beat + 2'd1}];
                        end
                    end
                end
                RECOVER: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_burst_responder.sv
// tb/tb_pmem_burst_responder.sv - scoreboard bench for two responders (latency 4 and latency 0)
module tb_pmem_burst_responder;
    localparam int DEPTH = 256;
    localparam int LAT0  = 4;
    localparam int LAT1  = 0;

    typedef struct packed {
        logic        is_wr;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [2];
    logic        rd     [2];
    logic        wr     [2];
    logic [31:0] addr   [2];
    logic [63:0] wd     [2];
    logic        resp_o [2];
    logic [63:0] rdata_o[2];
    logic        busy_o [2];
    logic        perr_o [2];
    logic [31:0] rdc_o  [2];
    logic [31:0] wrc_o  [2];

    pmem_burst_responder_if bus0 ();
    pmem_burst_responder_if bus1 ();

    assign bus0.pmem_read    = rd[0];
    assign bus0.pmem_write   = wr[0];
    assign bus0.pmem_address = addr[0];
    assign bus0.pmem_wdata   = wd[0];
    assign resp_o[0]         = bus0.pmem_resp;
    assign rdata_o[0]        = bus0.pmem_rdata;
    assign bus1.pmem_read    = rd[1];
    assign bus1.pmem_write   = wr[1];
    assign bus1.pmem_address = addr[1];
    assign bus1.pmem_wdata   = wd[1];
    assign resp_o[1]         = bus1.pmem_resp;
    assign rdata_o[1]        = bus1.pmem_rdata;

    pmem_burst_responder #(.LATENCY(LAT0), .DEPTH_LINES(DEPTH)) u_dut0 (
        .clk(clk), .rst(rst_n[0]), .bus(bus0), .busy(busy_o[0]),
        .proto_err(perr_o[0]), .rd_count(rdc_o[0]), .wr_count(wrc_o[0])
    );

    pmem_burst_responder #(.LATENCY(LAT1), .DEPTH_LINES(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst_n[1]), .bus(bus1), .busy(busy_o[1]),
        .proto_err(perr_o[1]), .rd_count(rdc_o[1]), .wr_count(wrc_o[1])
    );

    // Reference model: whole lines per unit, plus expected counters and error flag.
    logic [255:0] mdl    [2][DEPTH];
    bit           mvalid [2][DEPTH];
    int unsigned  rd_m   [2];
    int unsigned  wr_m   [2];
    bit           perr_m [2];

    exp_t exp_q[$];
    exp_t mon_e;
    int   cur   = 0;
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resp_o[cur] === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got resp=1 expected no beat (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (!mon_e.is_wr) begin
                    check("rdata", rdata_o[cur], mon_e.data);
                end
            end
        end
    end

    function automatic int line_of(input logic [31:0] a);
        return int'((a / 32) % DEPTH);
    endfunction

    task automatic chk_reset_outputs(input int u);
        check("rst_resp", resp_o[u], 0);
        check("rst_busy", busy_o[u], 0);
        check("rst_perr", perr_o[u], 0);
        check("rst_rdcnt", rdc_o[u], 0);
        check("rst_wrcnt", wrc_o[u], 0);
        check("rst_rdata", rdata_o[u], 0);
    endtask

    task automatic do_reset(input int u);
        @(negedge clk);
        rst_n[u] = 1'b0;
        rd[u] = 1'b0;
        wr[u] = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk_reset_outputs(u);
        rst_n[u] = 1'b1;
        rd_m[u] = 0;
        wr_m[u] = 0;
        perr_m[u] = 1'b0;
    endtask

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_busy", busy_o[u], 0);
            check("idle_resp", resp_o[u], 0);
        end
    endtask

    // rst_beat >= 0 asserts reset while that beat is on the bus.
    task automatic burst(input int u, input bit is_wr, input logic [31:0] a, input logic [255:0] wline,
                         input bit hold, input bit viol, input int rst_beat);
        int lat;
        int ln;
        logic [255:0] line_v;
        exp_t e;
        lat = (u == 0) ? LAT0 : LAT1;
        ln  = line_of(a);
        line_v = mdl[u][ln];
        @(negedge clk);
        rd[u] = !is_wr;
        wr[u] = is_wr;
        addr[u] = a;
        for (int k = 0; k < 4; k++) begin
            e.is_wr = is_wr;
            e.data  = is_wr ? wline[64*k +: 64] : line_v[64*k +: 64];
            exp_q.push_back(e);
        end
        for (int i = 1; i <= lat + 5; i++) begin
            bit exp_resp;
            @(negedge clk);
            exp_resp = (i >= lat + 1) && (i <= lat + 4);
            if (rst_beat >= 0 && i == lat + 1 + rst_beat) begin
                #1 rst_n[u] = 1'b0;
                #1 chk_reset_outputs(u);
                exp_q.delete();
                rd[u] = 1'b0;
                wr[u] = 1'b0;
                for (int k = 0; k < rst_beat; k++) line_v[64*k +: 64] = wline[64*k +: 64];
                mdl[u][ln] = line_v;
                rd_m[u] = 0;
                wr_m[u] = 0;
                perr_m[u] = 1'b0;
                @(negedge clk);
                rst_n[u] = 1'b1;
                return;
            end
            check("resp_timing", resp_o[u], exp_resp);
            if (exp_resp) wd[u] = wline[64*(i-lat-1) +: 64];
            if (viol && i == lat + 2) addr[u] = a ^ 32'h20;
            if (i == lat + 5) begin
                check("recover_busy", busy_o[u], 1);
                if (!hold) begin
                    rd[u] = 1'b0;
                    wr[u] = 1'b0;
                end
            end
        end
        if (is_wr) begin
            mdl[u][ln] = wline;
            mvalid[u][ln] = 1'b1;
            wr_m[u]++;
        end else begin
            rd_m[u]++;
        end
        if (viol) perr_m[u] = 1'b1;
        check("rd_count", rdc_o[u], 64'(rd_m[u]));
        check("wr_count", wrc_o[u], 64'(wr_m[u]));
        check("proto_err", perr_o[u], perr_m[u]);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom();
        return v;
    endfunction

    task automatic random_bursts(input int u, input int n);
        for (int j = 0; j < n; j++) begin
            int ln;
            bit w;
            bit h;
            logic [31:0] a;
            ln = $urandom_range(0, 7);
            w  = !mvalid[u][ln] || ($urandom_range(0, 1) == 1);
            h  = (j != n - 1) && ($urandom_range(0, 3) == 0);
            a  = ($urandom() & 32'hFFFF_E000) | (32'(ln) << 5) | 32'($urandom_range(0, 31));
            burst(u, w, a, rand_line(), h, 1'b0, -1);
            if (!h) idle(u, $urandom_range(0, 3));
        end
    endtask

    logic [255:0] wl_a;
    logic [255:0] wl_b;

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst_n[u] = 1'b0;
            rd[u] = 1'b0;
            wr[u] = 1'b0;
            addr[u] = 32'd0;
            wd[u] = 64'd0;
            rd_m[u] = 0;
            wr_m[u] = 0;
            perr_m[u] = 1'b0;
            for (int l = 0; l < DEPTH; l++) begin
                mdl[u][l] = '0;
                mvalid[u][l] = 1'b0;
            end
        end
        do_reset(0);
        do_reset(1);

        cur = 0;
        wl_a = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        burst(0, 1'b1, 32'h0000_0040, wl_a, 1'b0, 1'b0, -1);
        idle(0, 1);
        burst(0, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, -1);
        idle(0, 1);
        wl_b = rand_line();
        burst(0, 1'b1, 32'h0000_2040, wl_b, 1'b0, 1'b0, -1);
        burst(0, 1'b0, 32'h0000_0040, '0, 1'b0, 1'b0, -1);
        idle(0, 2);
        random_bursts(0, 40);

        @(negedge clk);
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        addr[0] = 32'h0000_0080;
        repeat (3) begin
            @(negedge clk);
            check("both_resp", resp_o[0], 0);
            check("both_busy", busy_o[0], 0);
        end
        check("both_perr", perr_o[0], 1);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        perr_m[0] = 1'b1;
        do_reset(0);

        burst(0, 1'b1, 32'h0000_0080, rand_line(), 1'b0, 1'b0, -1);
        burst(0, 1'b0, 32'h0000_0080, '0, 1'b0, 1'b1, -1);
        do_reset(0);

        burst(0, 1'b1, 32'h0000_00C0, rand_line(), 1'b0, 1'b0, -1);
        burst(0, 1'b1, 32'h0000_00C0, rand_line(), 1'b0, 1'b0, 2);
        burst(0, 1'b0, 32'h0000_00C0, '0, 1'b0, 1'b0, -1);
        idle(0, 2);

        cur = 1;
        burst(1, 1'b1, 32'h0000_0100, rand_line(), 1'b0, 1'b0, -1);
        idle(1, 1);
        burst(1, 1'b0, 32'h0000_0100, '0, 1'b1, 1'b0, -1);
        burst(1, 1'b0, 32'h0000_0100, '0, 1'b0, 1'b0, -1);
        idle(1, 2);
        random_bursts(1, 25);
        idle(1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
